wb_cmd_bridge_master: RTL and testbench

Command-driven Wishbone B4 pipelined bus master. A host issues 34-bit command words (set address, read, write). The block runs single Wishbone transactions on the bus and returns one 34-bit response word per command. It sits between a host or debug link and the system bus interconnect.

---
 rtl/wb_cmd_bridge_master_if.sv | 32 +++
 rtl/wb_cmd_bridge_master.sv | 129 ++++++++++++
 tb/tb_wb_cmd_bridge_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_bridge_master_if.sv
// Host command / Wishbone B4 pipelined bundle for wb_cmd_bridge_master.
// master = bridge view, slave = host+bus environment view.
interface wb_cmd_bridge_master_if;
    logic        i_cmd_stb;
    logic [33:0] i_cmd_word;
    logic        o_cmd_busy;
    logic        o_rsp_stb;
    logic [33:0] o_rsp_word;
    logic        i_wb_err;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [29:0] o_wb_addr;
    logic        o_wb_we;
    logic [31:0] o_wb_data;

    modport master (
        input  i_cmd_stb, i_cmd_word,
        input  i_wb_err, i_wb_stall, i_wb_ack, i_wb_data,
        output o_cmd_busy, o_rsp_stb, o_rsp_word,
        output o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_we, o_wb_data
    );

    modport slave (
        output i_cmd_stb, i_cmd_word,
        output i_wb_err, i_wb_stall, i_wb_ack, i_wb_data,
        input  o_cmd_busy, o_rsp_stb, o_rsp_word,
        input  o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_we, o_wb_data
    );
endinterface

// File: rtl/wb_cmd_bridge_master.sv
// Command-word driven Wishbone B4 pipelined master: one bus
// transaction and one response word per READ/WRITE/SET_ADDR command.
module wb_cmd_bridge_master (
    input  logic i_clk,
    input  logic i_reset,
    wb_cmd_bridge_master_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SETA  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic        inc_en_q, inc_en_d;
    logic        we_q, we_d;
    logic [31:0] data_q, data_d;
    logic        rsp_stb_q, rsp_stb_d;
    logic [33:0] rsp_word_q, rsp_word_d;

    logic [1:0]  op;
    logic [31:0] payload;
    logic        accept;
    logic        done;
    logic        fail;

    assign op      = bus.i_cmd_word[33:32];
    assign payload = bus.i_cmd_word[31:0];
    assign accept  = bus.i_cmd_stb && (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inc_en_d   = inc_en_q;
        we_d       = we_q;
        data_d     = data_q;
        rsp_stb_d  = 1'b0;
        rsp_word_d = rsp_word_q;
        done       = 1'b0;
        fail       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_READ, OP_WRITE: begin
                            state_d = S_REQ;
                            we_d    = (op == OP_WRITE);
                            data_d  = payload;
                        end
                        OP_SETA: begin
                            addr_d     = payload[29:0];
                            inc_en_d   = ~payload[30];
                            rsp_stb_d  = 1'b1;
                            rsp_word_d = {4'b0000, payload[29:0]};
                        end
                        OP_NOP: ;
                        default: ;
                    endcase
                end
            end
            S_REQ: begin
                // error aborts even while the slave is still stalling
                if (bus.i_wb_err) begin
                    fail = 1'b1;
                end else if (!bus.i_wb_stall) begin
                    if (bus.i_wb_ack) done = 1'b1;
                    else              state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_wb_err)      fail = 1'b1;
                else if (bus.i_wb_ack) done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            state_d    = S_IDLE;
            rsp_stb_d  = 1'b1;
            rsp_word_d = {2'b11, 32'h0};
        end

        if (done) begin
            state_d   = S_IDLE;
            rsp_stb_d = 1'b1;
            if (we_q) rsp_word_d = {2'b10, 32'h0};
            else      rsp_word_d = {2'b01, bus.i_wb_data};
            if (inc_en_q) addr_d = addr_q + 30'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            inc_en_q   <= 1'b1;
            we_q       <= 1'b0;
            data_q     <= '0;
            rsp_stb_q  <= 1'b0;
            rsp_word_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inc_en_q   <= inc_en_d;
            we_q       <= we_d;
            data_q     <= data_d;
            rsp_stb_q  <= rsp_stb_d;
            rsp_word_q <= rsp_word_d;
        end
    end

    assign bus.o_wb_cyc   = (state_q != S_IDLE);
    assign bus.o_wb_stb   = (state_q == S_REQ);
    assign bus.o_cmd_busy = (state_q != S_IDLE);
    assign bus.o_wb_addr  = addr_q;
    assign bus.o_wb_we    = we_q;
    assign bus.o_wb_data  = data_q;
    assign bus.o_rsp_stb  = rsp_stb_q;
    assign bus.o_rsp_word = rsp_word_q;

endmodule

// File: tb/tb_wb_cmd_bridge_master.sv
// Randomized bench for wb_cmd_bridge_master against a command-level
// model of address register, auto-increment and response words.
module tb_wb_cmd_bridge_master;

    logic clk;
    logic rst_n;

    wb_cmd_bridge_master_if bus ();

    wb_cmd_bridge_master dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    logic [29:0] m_addr;
    bit          m_inc;
    int          exp_rsp;
    int          seen_rsp;

    always @(negedge clk)
        if (rst_n && bus.o_rsp_stb) seen_rsp++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts and ends on a falling edge.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] pl,
                          input int stall_n, input int wait_n,
                          input bit err, input bit err_ack,
                          input bit junk, input logic [31:0] rd);
        logic [33:0] exp_word;
        bus.i_cmd_stb  = 1'b1;
        bus.i_cmd_word = {op, pl};
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
        cyc1();
        bus.i_cmd_stb = 1'b0;
        if (op == 2'b10) begin
            m_addr = pl[29:0];
            m_inc  = ~pl[30];
            exp_rsp++;
            check("sa_rsp_stb", bus.o_rsp_stb, 1);
            check("sa_rsp_word", bus.o_rsp_word, {4'b0, m_addr});
            check("sa_cyc", bus.o_wb_cyc, 0);
            check("sa_addr", bus.o_wb_addr, m_addr);
        end else if (op == 2'b11) begin
            check("nop_rsp_stb", bus.o_rsp_stb, 0);
            check("nop_busy", bus.o_cmd_busy, 0);
        end else begin
            check("rq_cyc", bus.o_wb_cyc, 1);
            check("rq_stb", bus.o_wb_stb, 1);
            check("rq_busy", bus.o_cmd_busy, 1);
            check("rq_we", bus.o_wb_we, op == 2'b01);
            check("rq_addr", bus.o_wb_addr, m_addr);
            check("rq_rsp_stb", bus.o_rsp_stb, 0);
            if (op == 2'b01) check("rq_data", bus.o_wb_data, pl);
            bus.i_cmd_stb  = junk;
            bus.i_cmd_word = {2'b01, 32'($urandom)};
            for (int i = 0; i < stall_n; i++) begin
                bus.i_wb_stall = 1'b1;
                bus.i_wb_ack   = 1'($urandom_range(0, 1));
                cyc1();
                check("stall_stb", bus.o_wb_stb, 1);
                check("stall_rsp", bus.o_rsp_stb, 0);
            end
            bus.i_wb_stall = 1'b0;
            bus.i_wb_ack   = 1'b0;
            for (int i = 0; i < wait_n; i++) begin
                cyc1();
                check("wait_stb", bus.o_wb_stb, 0);
                check("wait_cyc", bus.o_wb_cyc, 1);
            end
            if (err) begin
                bus.i_wb_err = 1'b1;
                bus.i_wb_ack = err_ack;
            end else begin
                bus.i_wb_ack = 1'b1;
            end
            bus.i_wb_data = rd;
            cyc1();
            bus.i_cmd_stb = 1'b0;
            bus.i_wb_ack  = 1'b0;
            bus.i_wb_err  = 1'b0;
            bus.i_wb_data = 32'($urandom);
            if (err)            exp_word = {2'b11, 32'h0};
            else if (op == 2'b00) exp_word = {2'b01, rd};
            else                exp_word = {2'b10, 32'h0};
            exp_rsp++;
            if (!err && m_inc) m_addr = m_addr + 30'd1;
            check("done_rsp_stb", bus.o_rsp_stb, 1);
            check("done_rsp_word", bus.o_rsp_word, exp_word);
            check("done_cyc", bus.o_wb_cyc, 0);
            check("done_busy", bus.o_cmd_busy, 0);
            check("done_addr", bus.o_wb_addr, m_addr);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_rsp = 0;
        seen_rsp = 0;
        m_addr = '0;
        m_inc = 1'b1;
        rst_n = 1'b0;
        bus.i_cmd_stb  = 1'b0;
        bus.i_cmd_word = '0;
        bus.i_wb_err   = 1'b0;
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_cyc", bus.o_wb_cyc, 0);
        check("rst_stb", bus.o_wb_stb, 0);
        check("rst_we", bus.o_wb_we, 0);
        check("rst_busy", bus.o_cmd_busy, 0);
        check("rst_rsp_stb", bus.o_rsp_stb, 0);
        check("rst_addr", bus.o_wb_addr, 0);
        check("rst_wdata", bus.o_wb_data, 0);
        check("rst_rsp_word", bus.o_rsp_word, 0);
        rst_n = 1'b1;
        cyc1();
        check("post_rst_busy", bus.o_cmd_busy, 0);
        check("post_rst_cyc", bus.o_wb_cyc, 0);

        do_cmd(2'b10, {2'b01, 30'h2AAAAAAA}, 0, 0, 0, 0, 0, 0);
        do_cmd(2'b01, 32'hAABBCCDD, 0, 1, 0, 0, 0, 0);
        check("nofinc_addr", bus.o_wb_addr, 30'h2AAAAAAA);
        do_cmd(2'b00, 0, 0, 0, 0, 0, 0, 32'h11223344);
        cyc1();
        check("rd_pulse_once", bus.o_rsp_stb, 0);

        do_cmd(2'b10, 32'd5, 0, 0, 0, 0, 0, 0);
        do_cmd(2'b00, 0, 3, 1, 0, 0, 0, 32'h5555AAAA);
        check("inc_addr", bus.o_wb_addr, 30'd6);

        do_cmd(2'b00, 0, 0, 1, 1, 1, 0, 32'hDEADBEEF);
        check("err_noinc", bus.o_wb_addr, 30'd6);

        do_cmd(2'b01, 32'h01020304, 2, 2, 0, 0, 1, 0);
        cyc1();
        check("junk_no_cyc", bus.o_wb_cyc, 0);

        do_cmd(2'b10, {2'b00, 30'h3FFFFFFF}, 0, 0, 0, 0, 0, 0);
        do_cmd(2'b01, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0);
        check("wrap_addr", bus.o_wb_addr, 30'd0);

        do_cmd(2'b11, 0, 0, 0, 0, 0, 0, 0);

        // reset in the middle of a stalled read
        bus.i_cmd_stb  = 1'b1;
        bus.i_cmd_word = {2'b00, 32'h0};
        cyc1();
        bus.i_cmd_stb  = 1'b0;
        bus.i_wb_stall = 1'b1;
        check("mid_cyc", bus.o_wb_cyc, 1);
        rst_n = 1'b0;
        #1;
        check("arst_cyc", bus.o_wb_cyc, 0);
        check("arst_stb", bus.o_wb_stb, 0);
        check("arst_addr", bus.o_wb_addr, 0);
        check("arst_rsp", bus.o_rsp_stb, 0);
        @(negedge clk);
        bus.i_wb_stall = 1'b0;
        rst_n = 1'b1;
        m_addr = '0;
        m_inc  = 1'b1;
        cyc1();
        check("arst_norsp", bus.o_rsp_stb, 0);

        for (int t = 0; t < 250; t++) begin
            logic [1:0]  op;
            logic [31:0] pl;
            op = 2'($urandom_range(0, 3));
            pl = $urandom;
            if (op == 2'b10 && $urandom_range(0, 3) == 0)
                pl[29:0] = 30'h3FFFFFFE;
            do_cmd(op, pl, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom);
        end

        repeat (2) cyc1();
        check("rsp_count", seen_rsp, exp_rsp);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
